// File: rtl/fft_out_reorder.sv
// FFT output reorder buffer. Two ping-pong banks take bit-reversed FFT
// output and the block streams each frame back out in natural bin order.
// out_vld/out_rdy handshake toward the consumer; the FFT core side has no backpressure.
module fft_out_reorder #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned MAX_STAGE  = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_vld,
    input  logic [3:0]            cfg_N,
    input  logic                  sig_start_i,
    input  logic                  sig_vld_i,
    input  logic [DATA_WIDTH-1:0] sig_real_i,
    input  logic [DATA_WIDTH-1:0] sig_imag_i,
    input  logic [MAX_STAGE-1:0]  N_index_i,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic                  out_start,
    output logic                  out_last,
    output logic [DATA_WIDTH-1:0] out_real,
    output logic [DATA_WIDTH-1:0] out_imag,
    output logic [MAX_STAGE-1:0]  out_bin,
    output logic                  frame_drop,
    output logic                  frame_err
);

    localparam int unsigned LW    = 4;
    localparam int unsigned AW    = MAX_STAGE + 1;
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned WW    = 2 * DATA_WIDTH;
    localparam logic [LW-1:0] L_MAX = LW'(MAX_STAGE);
    localparam logic [LW-1:0] L_MIN = LW'(3);

    typedef enum logic {W_IDLE, W_FILL} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_READ, R_WAIT} r_state_t;

    // Highest bin index of a frame of length 2^l.
    function automatic logic [MAX_STAGE-1:0] last_idx(input logic [LW-1:0] l);
        return {MAX_STAGE{1'b1}} >> (L_MAX - l);
    endfunction

    // Reverse the low l bits; reversing all bits and shifting drops the ignored upper bits.
    function automatic logic [MAX_STAGE-1:0] bit_rev(input logic [MAX_STAGE-1:0] idx,
                                                     input logic [LW-1:0] l);
        logic [MAX_STAGE-1:0] r;
        for (int i = 0; i < int'(MAX_STAGE); i++) r[i] = idx[MAX_STAGE-1-i];
        return r >> (L_MAX - l);
    endfunction

    logic [WW-1:0] mem [DEPTH];

    w_state_t               w_state;
    logic                   w_bank, w_pref;
    logic [MAX_STAGE-1:0]   w_cnt;
    logic [LW-1:0]          w_l, cur_l, pend_l;
    logic                   pend_vld;
    logic [1:0][LW-1:0]     bank_l;
    logic [1:0]             bank_full;

    r_state_t               r_state;
    logic                   r_bank, r_pref;
    logic [MAX_STAGE-1:0]   r_bin;
    logic [LW-1:0]          r_l;

    logic                   cfg_ok_c, start_c, sel_ok_c, sel_bank_c;
    logic [LW-1:0]          frame_l_c, wr_l_c;
    logic                   wr_en_c, wr_bank_c;
    logic [AW-1:0]          wr_addr_c;
    logic [1:0]             full_set_c, full_clr_c;
    logic                   xfer_c, done_c, rd_en_c, pick_c, arb_c;

    // Write-side bank selection, length selection and RAM write address.
    always_comb begin
        cfg_ok_c   = cfg_vld && (cfg_N >= L_MIN) && (cfg_N <= L_MAX);
        start_c    = sig_start_i && sig_vld_i;
        frame_l_c  = cur_l;
        if (pend_vld) frame_l_c = pend_l;
        if (cfg_ok_c) frame_l_c = cfg_N;
        sel_ok_c   = 1'b1;
        sel_bank_c = w_pref;
        if (bank_full[w_pref]) begin
            sel_bank_c = ~w_pref;
            sel_ok_c   = !bank_full[~w_pref];
        end
        wr_en_c    = 1'b0;
        wr_bank_c  = w_bank;
        wr_l_c     = w_l;
        full_set_c = '0;
        if (w_state == W_IDLE) begin
            wr_en_c   = start_c && sel_ok_c;
            wr_bank_c = sel_bank_c;
            wr_l_c    = frame_l_c;
        end else if (sig_vld_i) begin
            wr_en_c = 1'b1;
            if (start_c) wr_l_c = frame_l_c;
            else if (w_cnt == last_idx(w_l)) full_set_c[w_bank] = 1'b1;
        end
        wr_addr_c = {wr_bank_c, bit_rev(N_index_i, wr_l_c)};
    end

    // Read-side handshake, issue and arbitration decisions.
    always_comb begin
        xfer_c     = out_vld && out_rdy;
        done_c     = (r_state == R_WAIT) && xfer_c;
        rd_en_c    = (r_state == R_READ) && (!out_vld || out_rdy);
        pick_c     = done_c ? ~r_bank : r_pref;
        arb_c      = ((r_state == R_IDLE) || done_c) && bank_full[pick_c];
        full_clr_c = '0;
        if (done_c) full_clr_c[r_bank] = 1'b1;
    end

    // Sample storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wr_en_c) mem[wr_addr_c] <= {sig_real_i, sig_imag_i};
    end

    // Bank full flags: set by write completion, cleared by last output transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bank_full <= '0;
        else        bank_full <= (bank_full | full_set_c) & ~full_clr_c;
    end

    // Write FSM with length configuration and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state    <= W_IDLE;
            w_bank     <= 1'b0;
            w_pref     <= 1'b0;
            w_cnt      <= '0;
            w_l        <= L_MAX;
            cur_l      <= L_MAX;
            pend_l     <= L_MAX;
            pend_vld   <= 1'b0;
            bank_l     <= {L_MAX, L_MAX};
            frame_drop <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_drop <= 1'b0;
            frame_err  <= 1'b0;
            if (cfg_ok_c) begin
                if (w_state == W_IDLE) begin
                    cur_l    <= cfg_N;
                    pend_vld <= 1'b0;
                end else begin
                    pend_l   <= cfg_N;
                    pend_vld <= 1'b1;
                end
            end
            case (w_state)
                W_IDLE: begin
                    if (start_c) begin
                        if (sel_ok_c) begin
                            w_state  <= W_FILL;
                            w_bank   <= sel_bank_c;
                            w_cnt    <= MAX_STAGE'(1);
                            w_l      <= frame_l_c;
                            cur_l    <= frame_l_c;
                            pend_vld <= 1'b0;
                        end else begin
                            frame_drop <= 1'b1;
                        end
                    end
                end
                W_FILL: begin
                    if (sig_vld_i) begin
                        if (start_c) begin
                            frame_err <= 1'b1;
                            w_cnt     <= MAX_STAGE'(1);
                            w_l       <= frame_l_c;
                            cur_l     <= frame_l_c;
                            pend_vld  <= 1'b0;
                        end else if (|full_set_c) begin
                            w_state        <= W_IDLE;
                            bank_l[w_bank] <= w_l;
                            w_pref         <= ~w_bank;
                        end else begin
                            w_cnt <= w_cnt + MAX_STAGE'(1);
                        end
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read FSM; the output register doubles as the RAM read register so a stall holds it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= R_IDLE;
            r_bank    <= 1'b0;
            r_pref    <= 1'b0;
            r_bin     <= '0;
            r_l       <= L_MAX;
            out_vld   <= 1'b0;
            out_start <= 1'b0;
            out_last  <= 1'b0;
            out_real  <= '0;
            out_imag  <= '0;
            out_bin   <= '0;
        end else begin
            if (rd_en_c) begin
                out_vld              <= 1'b1;
                {out_real, out_imag} <= mem[{r_bank, r_bin}];
                out_bin              <= r_bin;
                out_start            <= (r_bin == '0);
                out_last             <= (r_bin == last_idx(r_l));
                if (r_bin == last_idx(r_l)) r_state <= R_WAIT;
                else                        r_bin   <= r_bin + MAX_STAGE'(1);
            end else if (xfer_c) begin
                out_vld   <= 1'b0;
                out_start <= 1'b0;
                out_last  <= 1'b0;
            end
            if (done_c) begin
                r_state <= R_IDLE;
                r_pref  <= ~r_bank;
            end
            if (arb_c) begin
                r_state <= R_READ;
                r_bank  <= pick_c;
                r_bin   <= '0;
                r_l     <= bank_l[pick_c];
            end
        end
    end

endmodule

// File: tb/tb_fft_out_reorder.sv
// Bench for fft_out_reorder: directed frames, scoreboard of natural-order beats.
module tb_fft_out_reorder;

    localparam int unsigned DW = 16;
    localparam int unsigned MS = 12;

    logic          clk;
    logic          rst_n;
    logic          cfg_vld;
    logic [3:0]    cfg_N;
    logic          sig_start_i;
    logic          sig_vld_i;
    logic [DW-1:0] sig_real_i;
    logic [DW-1:0] sig_imag_i;
    logic [MS-1:0] N_index_i;
    logic          out_vld;
    logic          out_rdy;
    logic          out_start;
    logic          out_last;
    logic [DW-1:0] out_real;
    logic [DW-1:0] out_imag;
    logic [MS-1:0] out_bin;
    logic          frame_drop;
    logic          frame_err;

    fft_out_reorder #(.DATA_WIDTH(DW), .MAX_STAGE(MS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_vld    (cfg_vld),
        .cfg_N      (cfg_N),
        .sig_start_i(sig_start_i),
        .sig_vld_i  (sig_vld_i),
        .sig_real_i (sig_real_i),
        .sig_imag_i (sig_imag_i),
        .N_index_i  (N_index_i),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .out_start  (out_start),
        .out_last   (out_last),
        .out_real   (out_real),
        .out_imag   (out_imag),
        .out_bin    (out_bin),
        .frame_drop (frame_drop),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [MS-1:0] bin;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic          st;
        logic          la;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    n_beats  = 0;
    int    rdy_mode = 0;

    function automatic logic [MS-1:0] brev(input logic [MS-1:0] v, input int l);
        logic [MS-1:0] r = '0;
        for (int i = 0; i < l; i++) r[4'(i)] = v[4'(l - 1 - i)];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Natural-order expectation: bin b of a frame carries base+b / ~(base+b).
    task automatic push_frame(input int l, input int base);
        beat_t e;
        int n = 1 << l;
        for (int b = 0; b < n; b++) begin
            e.bin = MS'(b);
            e.re  = DW'(base + b);
            e.im  = ~DW'(base + b);
            e.st  = (b == 0);
            e.la  = (b == n - 1);
            exp_q.push_back(e);
        end
    endtask

    // Drives nb beats in core order; natural sample k carries base+k. Upper index bits are junk.
    task automatic drive_frame(input int l, input int base, input int nb, input int pulse,
                               input int cfg_at, input logic [3:0] cfg_val);
        logic [MS-1:0] idx;
        for (int k = 0; k < nb; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                check("frame_drop_pulse", frame_drop, pulse == 1);
                check("frame_err_pulse", frame_err, pulse == 2);
            end
            if (k == 2) begin
                check("frame_drop_clear", frame_drop, 0);
                check("frame_err_clear", frame_err, 0);
            end
            idx = brev(MS'(k), l);
            for (int i = l; i < int'(MS); i++) idx[4'(i)] = 1'b1;
            sig_vld_i   = 1'b1;
            sig_start_i = (k == 0);
            N_index_i   = idx;
            sig_real_i  = DW'(base + k);
            sig_imag_i  = ~DW'(base + k);
            cfg_vld     = (k == cfg_at);
            cfg_N       = cfg_val;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            sig_vld_i   = 1'b0;
            sig_start_i = 1'b0;
            cfg_vld     = 1'b0;
        end
    endtask

    task automatic cfg_strobe(input logic [3:0] v);
        @(posedge clk); #1;
        sig_vld_i   = 1'b0;
        sig_start_i = 1'b0;
        cfg_vld     = 1'b1;
        cfg_N       = v;
        idle(1);
    endtask

    task automatic wait_drain(input int budget);
        for (int c = 0; c < budget && exp_q.size() != 0; c++) @(posedge clk);
        check("drain_complete", exp_q.size(), 0);
    endtask

    // Pops and compares every transferred beat; checks that a stalled beat holds.
    task automatic monitor();
        beat_t cur, prev, e;
        logic  prev_stall = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                continue;
            end
            cur = {out_bin, out_real, out_imag, out_start, out_last};
            if (prev_stall) begin
                check("stall_vld_hold", out_vld, 1);
                check("stall_data_hold", cur, prev);
            end
            if (out_vld && out_rdy) begin
                n_beats++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL extra_beat: got bin %0d real 0x%0h, expected no beat", out_bin, out_real);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", cur, e);
                end
            end
            prev_stall = out_vld && !out_rdy;
            prev       = cur;
        end
    endtask

    task automatic rdy_driver();
        forever begin
            @(posedge clk); #1;
            if (rdy_mode == 0)      out_rdy = 1'b1;
            else if (rdy_mode == 1) out_rdy = 1'b0;
            else                    out_rdy = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        int snap;
        rst_n       = 1'b0;
        cfg_vld     = 1'b0;
        cfg_N       = 4'd0;
        sig_start_i = 1'b0;
        sig_vld_i   = 1'b0;
        sig_real_i  = '0;
        sig_imag_i  = '0;
        N_index_i   = '0;
        out_rdy     = 1'b1;
        fork
            monitor();
            rdy_driver();
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_vld", out_vld, 0);
        check("rst_out_start", out_start, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_real", out_real, 0);
        check("rst_out_imag", out_imag, 0);
        check("rst_out_bin", out_bin, 0);
        check("rst_frame_drop", frame_drop, 0);
        check("rst_frame_err", frame_err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full-length frame at reset default L=12, cfg for L=10 arrives mid-frame.
        push_frame(12, 0);
        drive_frame(12, 0, 4096, 0, 2000, 4'd10);
        idle(1);
        check("latency_edge1", out_vld, 0);
        idle(1);
        check("latency_edge2", out_vld, 0);
        idle(1);
        check("latency_edge3", out_vld, 1);
        wait_drain(5000);

        // Pending L=10 takes effect on this frame.
        push_frame(10, 16'h1000);
        drive_frame(10, 16'h1000, 1024, 0, -1, 4'd0);
        idle(1);
        wait_drain(3000);
        idle(5);

        // Both banks fill while stalled; a third frame is dropped.
        rdy_mode = 1;
        idle(2);
        snap = n_beats;
        push_frame(10, 16'h2000);
        push_frame(10, 16'h3000);
        drive_frame(10, 16'h2000, 1024, 0, -1, 4'd0);
        drive_frame(10, 16'h3000, 1024, 0, -1, 4'd0);
        drive_frame(10, 16'h7777, 1024, 1, -1, 4'd0);
        idle(5);
        check("stalled_no_beats", n_beats, snap);
        rdy_mode = 0;
        wait_drain(5000);
        idle(20);
        check("released_beat_count", n_beats - snap, 2048);

        // L=8 frame with random downstream ready.
        cfg_strobe(4'd8);
        rdy_mode = 2;
        push_frame(8, 16'h6000);
        drive_frame(8, 16'h6000, 256, 0, -1, 4'd0);
        idle(1);
        wait_drain(3000);
        rdy_mode = 0;
        idle(5);

        // Restart at sample 500: partial frame discarded.
        cfg_strobe(4'd10);
        drive_frame(10, 16'h4400, 500, 0, -1, 4'd0);
        push_frame(10, 16'h8000);
        drive_frame(10, 16'h8000, 1024, 2, -1, 4'd0);
        idle(1);
        wait_drain(3000);
        idle(5);

        // Out-of-range lengths are ignored; L stays 10.
        cfg_strobe(4'd2);
        cfg_strobe(4'd13);
        push_frame(10, 16'h9000);
        drive_frame(10, 16'h9000, 1024, 0, -1, 4'd0);
        idle(1);
        wait_drain(3000);
        idle(5);

        // Reset in the middle of reading out a frame.
        snap = n_beats;
        push_frame(10, 16'hA000);
        drive_frame(10, 16'hA000, 1024, 0, -1, 4'd0);
        idle(1);
        for (int c = 0; c < 500 && (n_beats - snap) < 100; c++) @(posedge clk);
        check("beats_before_reset", (n_beats - snap) >= 100, 1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("midread_rst_vld", out_vld, 0);
        check("midread_rst_last", out_last, 0);
        check("midread_rst_bin", out_bin, 0);
        exp_q.delete();
        snap = n_beats;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(40);
        check("no_beats_after_reset", n_beats, snap);
        check("vld_low_after_reset", out_vld, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_out_reorder.md
FFT_OUT_REORDER -- requirements
Module: fft_out_reorder

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of each real/imag sample.
REQ-002 Parameter MAX_STAGE, default 12: log2 of max FFT length; each bank holds 2^MAX_STAGE complex words.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cfg_vld  input  1  single-cycle strobe qualifying cfg_N.
REQ-006 cfg_N  input  4  log2 frame length; legal range 3..MAX_STAGE.
REQ-007 sig_start_i  input  1  first sample of FFT output frame; honored only with sig_vld_i=1.
REQ-008 sig_vld_i  input  1  sample valid from FFT core; no backpressure toward core.
REQ-009 sig_real_i / sig_imag_i  input  DATA_WIDTH each  sample data.
REQ-010 N_index_i  input  MAX_STAGE  core-order (bit-reversed) bin index of current sample.
REQ-011 out_vld  output  1  natural-order output valid.
REQ-012 out_rdy  input  1  downstream ready; beat transfers when out_vld & out_rdy.
REQ-013 out_start / out_last  output  1 each  first / last beat of output frame.
REQ-014 out_real / out_imag  output  DATA_WIDTH each  output data.
REQ-015 out_bin  output  MAX_STAGE  natural bin index of current beat.
REQ-016 frame_drop / frame_err  output  1 each  single-cycle status pulses.

Function
REQ-017 Active length L SHALL be latched from cfg_N on cfg_vld when write FSM is W_IDLE; cfg_vld during W_FILL SHALL be applied at next frame start; cfg_N outside 3..MAX_STAGE SHALL be ignored.
REQ-018 Two banks (ping-pong); each bank SHALL carry a full flag and its own latched L.
REQ-019 Write FSM W_IDLE -> W_FILL on sig_start_i&sig_vld_i when a non-full bank exists (bank 0 preferred after reset, then alternating); that beat is sample 0.
REQ-020 In W_FILL each sig_vld_i beat SHALL be written at address = bit-reverse of N_index_i[L-1:0] over L bits; higher N_index_i bits ignored.
REQ-021 On the edge capturing sample 2^L-1, bank SHALL be marked full and FSM return to W_IDLE.
REQ-022 sig_start_i&sig_vld_i while in W_FILL: frame_err pulse, partial bank discarded (not marked full), new frame restarts in same bank with that beat as sample 0.
REQ-023 sig_start_i&sig_vld_i in W_IDLE with both banks full: frame_drop pulse, entire frame ignored until next start.
REQ-024 sig_vld_i without start in W_IDLE SHALL be ignored.
REQ-025 Read FSM R_IDLE -> R_READ when oldest full bank exists; reads bins 0..2^L-1 ascending, out_bin = bin.
REQ-026 First out_vld SHALL rise exactly 2 cycles after the edge writing the last sample (1-cycle synchronous RAM read).
REQ-027 out_start with bin 0, out_last with bin 2^L-1; after last transfer bank full flag cleared and FSM re-arbitrates the same cycle, allowing back-to-back frames with at most 1 idle cycle.
REQ-028 While out_vld&!out_rdy all out_* SHALL hold stable; no beat lost or duplicated.
REQ-029 Bank freed by read SHALL be writable in the cycle after its flag clears; simultaneous write-complete and read-free on different banks SHALL both take effect.

Reset
REQ-030 On rst_n low: out_vld, out_start, out_last, frame_drop, frame_err = 0; out_real, out_imag, out_bin = 0; both banks empty; FSMs idle; L = MAX_STAGE.
REQ-031 Reset mid-frame SHALL discard all stored and partial frames; RAM contents need not clear.

Verification
REQ-032 Reset, L=12, feed 4096 beats with N_index_i = bitrev12(k), data=k -> 4096 beats out_real=0..4095 ascending, out_start at bin 0, out_last at bin 4095, first out_vld 2 cycles after last input.
REQ-033 cfg_vld cfg_N=10 mid-4096 frame -> that frame completes at 4096, next 1024-beat frame reorders with 10-bit reversal, out_last at bin 1023.
REQ-034 Two back-to-back 1024 frames, out_rdy=0 throughout, then third start -> frame_drop=1 one cycle, after release exactly 2048 beats emitted in order.
REQ-035 out_rdy toggling random 50% during 256-bin frame (L=8) -> data stable while stalled, 256 unique ascending bins.
REQ-036 New sig_start_i at sample 500 of 1024 frame -> frame_err pulse, partial data never emitted, restarted frame output complete.
REQ-037 cfg_N=2 and cfg_N=13 strobes -> L unchanged; rst_n low mid-read -> out_vld=0 immediately, no further beats.
